pipe_skid_stage: RTL and testbench

PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

---
 rtl/pipe_pkg.sv | 23 ++
 rtl/pipe_skid_stage_if.sv | 22 ++
 rtl/pipe_slot.sv | 33 +++
 rtl/pipe_skid_stage.sv | 130 +++++++++++++
 tb/tb_pipe_skid_stage.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the skid-buffered pipeline stage: state encoding,
// default bubble payload fill and the state-to-occupancy helper.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } stage_state_e;

    localparam int unsigned DATA_W_DEFAULT = 80;
    localparam logic        NOP_FILL_BIT   = 1'b0;

    function automatic logic [1:0] state_count(input stage_state_e st);
        case (st)
            ST_EMPTY: return 2'd0;
            ST_ONE:   return 2'd1;
            ST_TWO:   return 2'd2;
            default:  return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_skid_stage_if.sv
// Valid/ready handshake bundle between upstream, the skid stage and downstream.
interface pipe_skid_stage_if #(
    parameter int unsigned DATA_W = 80
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;

    // Environment side: produces upstream payloads and consumes downstream ones
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/pipe_slot.sv
// Single payload register with load enable; reset and clear both restore the bubble value.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int unsigned       DATA_W    = DATA_W_DEFAULT,
    parameter logic [DATA_W-1:0] NOP_VALUE = {DATA_W{NOP_FILL_BIT}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              load,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] data_r;

    // Payload register: rst beats clear beats load
    always_ff @(posedge clk) begin
        if (rst) begin
            data_r <= NOP_VALUE;
        end else if (clear) begin
            data_r <= NOP_VALUE;
        end else if (load) begin
            data_r <= d;
        end else begin
            data_r <= data_r;
        end
    end

    assign q = data_r;

endmodule

// File: rtl/pipe_skid_stage.sv
// Two-entry skid stage: full-throughput valid/ready pipeline register whose
// in_ready is registered, cutting the combinational out_ready->in_ready path.
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int unsigned       DATA_W    = DATA_W_DEFAULT,
    parameter logic [DATA_W-1:0] NOP_VALUE = {DATA_W{NOP_FILL_BIT}}
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    pipe_skid_stage_if.slave    bus,
    output logic [1:0]          occupancy
);

    stage_state_e      state_r;
    stage_state_e      state_nxt_s;
    logic              in_ready_r;
    logic              accept_s;
    logic              drain_s;
    logic              out_valid_s;
    logic              main_load_s;
    logic              main_clear_s;
    logic              skid_load_s;
    logic              skid_clear_s;
    logic [DATA_W-1:0] main_d_s;
    logic [DATA_W-1:0] main_q_s;
    logic [DATA_W-1:0] skid_q_s;

    assign out_valid_s = (state_r != ST_EMPTY);
    assign accept_s    = bus.in_valid & in_ready_r;
    assign drain_s     = out_valid_s & bus.out_ready;

    // Next-state and slot control; flush overrides the handshake and drops everything
    always_comb begin
        state_nxt_s  = state_r;
        main_load_s  = 1'b0;
        main_clear_s = 1'b0;
        skid_load_s  = 1'b0;
        skid_clear_s = 1'b0;
        main_d_s     = bus.in_data;
        if (flush) begin
            state_nxt_s  = ST_EMPTY;
            main_clear_s = 1'b1;
            skid_clear_s = 1'b1;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (accept_s) begin
                        main_load_s = 1'b1;
                        state_nxt_s = ST_ONE;
                    end else begin
                        state_nxt_s = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (accept_s && drain_s) begin
                        main_load_s = 1'b1;
                        state_nxt_s = ST_ONE;
                    end else if (accept_s) begin
                        skid_load_s = 1'b1;
                        state_nxt_s = ST_TWO;
                    end else if (drain_s) begin
                        main_clear_s = 1'b1;
                        state_nxt_s  = ST_EMPTY;
                    end else begin
                        state_nxt_s = ST_ONE;
                    end
                end
                ST_TWO: begin
                    // in_ready is low here, so only the drain side can move
                    if (drain_s) begin
                        main_d_s     = skid_q_s;
                        main_load_s  = 1'b1;
                        skid_clear_s = 1'b1;
                        state_nxt_s  = ST_ONE;
                    end else begin
                        state_nxt_s = ST_TWO;
                    end
                end
                default: begin
                    state_nxt_s  = ST_EMPTY;
                    main_clear_s = 1'b1;
                    skid_clear_s = 1'b1;
                end
            endcase
        end
    end

    // State register and look-ahead ready: ready next cycle unless both slots will be full
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_EMPTY;
            in_ready_r <= 1'b1;
        end else begin
            state_r    <= state_nxt_s;
            in_ready_r <= (state_nxt_s != ST_TWO);
        end
    end

    pipe_slot #(
        .DATA_W    (DATA_W),
        .NOP_VALUE (NOP_VALUE)
    ) u_main_slot (
        .clk   (clk),
        .rst   (rst),
        .clear (main_clear_s),
        .load  (main_load_s),
        .d     (main_d_s),
        .q     (main_q_s)
    );

    pipe_slot #(
        .DATA_W    (DATA_W),
        .NOP_VALUE (NOP_VALUE)
    ) u_skid_slot (
        .clk   (clk),
        .rst   (rst),
        .clear (skid_clear_s),
        .load  (skid_load_s),
        .d     (bus.in_data),
        .q     (skid_q_s)
    );

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_s;
    assign bus.out_data  = main_q_s;
    assign occupancy     = state_count(state_r);

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed and scoreboard-checked bench for pipe_skid_stage at DATA_W=8, NOP=00.
module tb_pipe_skid_stage;

    logic       clk;
    logic       rst;
    logic       flush;
    logic [1:0] occupancy;
    int         total_cnt;
    int         bad_cnt;
    logic [7:0] model_q[$];

    pipe_skid_stage_if #(.DATA_W(8)) bus ();

    pipe_skid_stage #(
        .DATA_W    (8),
        .NOP_VALUE (8'h00)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .bus       (bus.slave),
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        total_cnt++;
        if (obs !== exp_v) begin
            bad_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic vld, input logic [7:0] dat,
                           input logic rdy, input logic [1:0] occ);
        chk({tag, ".out_valid"}, 16'(bus.out_valid), 16'(vld));
        chk({tag, ".out_data"},  16'(bus.out_data),  16'(dat));
        chk({tag, ".in_ready"},  16'(bus.in_ready),  16'(rdy));
        chk({tag, ".occupancy"}, 16'(occupancy),     16'(occ));
    endtask

    initial begin
        logic       do_acc;
        logic [1:0] sz;
        total_cnt     = 0;
        bad_cnt       = 0;
        rst           = 1'b1;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk_out("reset", 1'b0, 8'h00, 1'b1, 2'd0);

        // single beat, one-cycle latency
        bus.in_valid = 1'b1; bus.in_data = 8'hA5; bus.out_ready = 1'b1;
        step();
        bus.in_valid = 1'b0; bus.in_data = 8'h00;
        chk_out("single", 1'b1, 8'hA5, 1'b1, 2'd1);
        step();
        chk_out("single_drained", 1'b0, 8'h00, 1'b1, 2'd0);

        // backpressure fills skid, held beat waits
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_data = 8'h11;
        step();
        chk_out("bp_one", 1'b1, 8'h11, 1'b1, 2'd1);
        bus.in_data = 8'h22;
        step();
        chk_out("bp_two", 1'b1, 8'h11, 1'b0, 2'd2);
        bus.in_data = 8'h33;
        step();
        chk_out("bp_hold", 1'b1, 8'h11, 1'b0, 2'd2);
        bus.out_ready = 1'b1;
        step();
        chk_out("bp_emit22", 1'b1, 8'h22, 1'b1, 2'd1);
        step();
        bus.in_valid = 1'b0; bus.in_data = 8'h00;
        chk_out("bp_emit33", 1'b1, 8'h33, 1'b1, 2'd1);
        step();
        chk_out("bp_empty", 1'b0, 8'h00, 1'b1, 2'd0);

        // streaming at full rate
        for (int i = 1; i <= 10; i++) begin
            bus.in_valid = 1'b1; bus.in_data = 8'(i);
            step();
            chk("stream.out_valid", 16'(bus.out_valid), 16'h0001);
            chk("stream.out_data",  16'(bus.out_data),  16'(i));
            chk("stream.occupancy", 16'(occupancy),     16'h0001);
        end
        bus.in_valid = 1'b0; bus.in_data = 8'h00;
        step();
        chk_out("stream_end", 1'b0, 8'h00, 1'b1, 2'd0);

        // flush while full with a same-cycle incoming beat
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_data = 8'h55;
        step();
        bus.in_data = 8'h66;
        step();
        chk_out("pre_flush", 1'b1, 8'h55, 1'b0, 2'd2);
        flush = 1'b1; bus.in_data = 8'h44;
        step();
        flush = 1'b0; bus.in_valid = 1'b0; bus.in_data = 8'h00;
        chk_out("flush", 1'b0, 8'h00, 1'b1, 2'd0);
        bus.out_ready = 1'b1;
        step();
        chk_out("flush_after", 1'b0, 8'h00, 1'b1, 2'd0);

        // reset while holding one entry, then accept right after
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_data = 8'h77;
        step();
        chk_out("hold77", 1'b1, 8'h77, 1'b1, 2'd1);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_out("mid_rst", 1'b0, 8'h00, 1'b1, 2'd0);
        bus.in_valid = 1'b1; bus.in_data = 8'h88;
        step();
        bus.in_valid = 1'b0;
        chk_out("first_after_rst", 1'b1, 8'h88, 1'b1, 2'd1);

        // random traffic against a queue model
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_q.delete();
        for (int c = 0; c < 10000; c++) begin
            sz = 2'(model_q.size());
            chk("rnd.out_valid", 16'(bus.out_valid), 16'(sz != 2'd0));
            chk("rnd.out_data",  16'(bus.out_data),  (sz != 2'd0) ? 16'(model_q[0]) : 16'h0000);
            chk("rnd.in_ready",  16'(bus.in_ready),  16'(sz != 2'd2));
            chk("rnd.occupancy", 16'(occupancy),     16'(sz));
            bus.in_valid  = ($urandom_range(3) != 0);
            bus.in_data   = 8'($urandom_range(255));
            bus.out_ready = ($urandom_range(1) != 0);
            flush         = ($urandom_range(15) == 0);
            if (flush) begin
                model_q.delete();
            end else begin
                do_acc = bus.in_valid && (sz != 2'd2);
                if (bus.out_ready && (sz != 2'd0)) void'(model_q.pop_front());
                if (do_acc) model_q.push_back(bus.in_data);
            end
            step();
        end
        flush = 1'b0; bus.in_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
